// File: rtl/valu_lane_sequencer.sv
// valu_lane_sequencer
// Multi-cycle vector ALU sequencer: one instruction in flight, one lane per
// cycle through a shared external half-precision adder and multiplier.
// Optional feature macro: VALU_ILLEGAL_CHK_EN (adds the illegal port and
// flags opcodes 1001-1110; without it those opcodes behave as NOP).
module valu_lane_sequencer #(
    parameter int unsigned LANES = 16,
    parameter int unsigned LW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            opcode,
    input  logic [LANES*LW-1:0]   op_1,
    input  logic [LANES*LW-1:0]   op_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*LW-1:0]   result,
    output logic                  busy,
`ifdef VALU_ILLEGAL_CHK_EN
    output logic                  illegal,
`endif
    output logic [LW-1:0]         fadd_a,
    output logic [LW-1:0]         fadd_b,
    input  logic [LW-1:0]         fadd_sum,
    output logic [LW-1:0]         fmul_a,
    output logic [LW-1:0]         fmul_b,
    input  logic [LW-1:0]         fmul_prod
);

    localparam int unsigned VW = LANES * LW;
    localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;

    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    logic [1:0]    state;
    logic [3:0]    op_q;
    logic [VW-1:0] op1_q;
    logic [VW-1:0] op2_q;
    logic [CW-1:0] cnt;
    logic [LW-1:0] acc;
    logic [VW-1:0] result_q;
    logic [LW-1:0] lane_a;
    logic [LW-1:0] lane_b;
    logic          is_vec_op;
    logic          last_lane;

`ifdef VALU_ILLEGAL_CHK_EN
    logic          illegal_q;
    logic          opcode_illegal;

    // Opcodes 1001..1110 are unassigned and get flagged on accept
    always_comb begin
        opcode_illegal = (opcode >= 4'b1001) && (opcode <= 4'b1110);
    end

    assign illegal = illegal_q;
`endif

    // Decode which opcodes are executed lane-by-lane here
    always_comb begin
        is_vec_op = (opcode == OP_VADD) || (opcode == OP_VDOT) || (opcode == OP_SMUL);
    end

    // Current lane operands selected by the lane counter
    always_comb begin
        lane_a    = op1_q[cnt*LW +: LW];
        lane_b    = op2_q[cnt*LW +: LW];
        last_lane = (cnt == LAST_LANE);
    end

    // Float-unit operand steering; everything unused is held at zero
    always_comb begin
        fadd_a = '0;
        fadd_b = '0;
        fmul_a = '0;
        fmul_b = '0;
        if (state == ST_RUN) begin
            case (op_q)
                OP_VADD: begin
                    fadd_a = lane_a;
                    fadd_b = lane_b;
                end
                OP_SMUL: begin
                    fmul_a = op2_q[LW-1:0];
                    fmul_b = lane_a;
                end
                OP_VDOT: begin
                    fmul_a = lane_a;
                    fmul_b = lane_b;
                    fadd_a = acc;
                    fadd_b = fmul_prod;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, lane counter, accumulator and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            cnt       <= '0;
            acc       <= '0;
            result_q  <= '0;
`ifdef VALU_ILLEGAL_CHK_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        result_q <= '0;
                        if (is_vec_op) begin
                            op_q  <= opcode;
                            op1_q <= op_1;
                            op2_q <= op_2;
                            cnt   <= '0;
                            acc   <= '0;
                            state <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                        end
`ifdef VALU_ILLEGAL_CHK_EN
                        illegal_q <= opcode_illegal;
`endif
                    end
                end
                ST_RUN: begin
                    case (op_q)
                        OP_VADD: result_q[cnt*LW +: LW] <= fadd_sum;
                        OP_SMUL: result_q[cnt*LW +: LW] <= fmul_prod;
                        OP_VDOT: begin
                            acc <= fadd_sum;
                            // The dot product lands in lane 0 only on the final lane;
                            // upper lanes stay at the zero written on accept.
                            if (last_lane) begin
                                result_q[LW-1:0] <= fadd_sum;
                            end
                        end
                        default: ;
                    endcase
                    if (last_lane) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_RUN) || (state == ST_DONE);
        result    = result_q;
    end

endmodule

// File: tb/tb_valu_lane_sequencer.sv
// Testbench for valu_lane_sequencer: behavioural float units, a
// transaction-level reference model, a per-cycle compare process, and
// directed plus randomized stimulus.
module tb_valu_lane_sequencer;

    localparam int LANES = 16;
    localparam int LW    = 16;
    localparam int VW    = LANES * LW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [VW-1:0] op_1;
    logic [VW-1:0] op_2;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] result;
    logic          busy;
`ifdef VALU_ILLEGAL_CHK_EN
    logic          illegal;
`endif
    logic [LW-1:0] fadd_a, fadd_b, fadd_sum;
    logic [LW-1:0] fmul_a, fmul_b, fmul_prod;

    int n_tests = 0;
    int n_fail  = 0;

    valu_lane_sequencer #(.LANES(LANES), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .op_1      (op_1),
        .op_2      (op_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
`ifdef VALU_ILLEGAL_CHK_EN
        .illegal   (illegal),
`endif
        .fadd_a    (fadd_a),
        .fadd_b    (fadd_b),
        .fadd_sum  (fadd_sum),
        .fmul_a    (fmul_a),
        .fmul_b    (fmul_b),
        .fmul_prod (fmul_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- half-precision helpers (normals and zero) ----------
    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        if (e > 15) begin
            for (int i = 0; i < e - 15; i++) v = v * 2.0;
        end else begin
            for (int i = 0; i < 15 - e; i++) v = v / 2.0;
        end
        if (h[15]) v = -v;
        return v;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic [63:0] b;
        int          e;
        logic [4:0]  ef;
        if (r == 0.0) return 16'h0000;
        b  = $realtobits(r);
        e  = int'(b[62:52]) - 1023 + 15;
        if (e <= 0)  return {b[63], 15'h0};
        if (e >= 31) return {b[63], 5'h1f, 10'h0};
        ef = e[4:0];
        return {b[63], ef, b[51:42]};
    endfunction

    function automatic logic [15:0] f_add(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] f_mul(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) * h2r(b));
    endfunction

    // External float units, purely combinational
    assign fadd_sum  = f_add(fadd_a, fadd_b);
    assign fmul_prod = f_mul(fmul_a, fmul_b);

    // ---------------- reference model ------------------------------------
    function automatic logic is_vec(input logic [3:0] o);
        return (o == 4'd0) || (o == 4'd1) || (o == 4'd2);
    endfunction

    function automatic logic [15:0] dot_acc(input logic [VW-1:0] a, input logic [VW-1:0] b, input int k);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i < k; i++) acc = f_add(acc, f_mul(a[i*LW +: LW], b[i*LW +: LW]));
        return acc;
    endfunction

    function automatic logic [VW-1:0] expect_result(input logic [3:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = '0;
        case (o)
            4'd0: for (int i = 0; i < LANES; i++) r[i*LW +: LW] = f_add(a[i*LW +: LW], b[i*LW +: LW]);
            4'd2: for (int i = 0; i < LANES; i++) r[i*LW +: LW] = f_mul(b[LW-1:0], a[i*LW +: LW]);
            4'd1: r[LW-1:0] = dot_acc(a, b, LANES);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic expect_ill(input logic [3:0] o);
`ifdef VALU_ILLEGAL_CHK_EN
        return (o >= 4'd9) && (o <= 4'd14);
`else
        return (o == 4'hF) && (o != 4'hF);
`endif
    endfunction

    // One instruction in flight: m_left counts cycles until the result shows
    logic          m_busy;
    int            m_left;
    logic [3:0]    m_op;
    logic [VW-1:0] m_a, m_b, m_res;
    logic          m_ill;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_op   <= 4'd0;
            m_a    <= '0;
            m_b    <= '0;
            m_res  <= '0;
            m_ill  <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_op   <= opcode;
                m_a    <= op_1;
                m_b    <= op_2;
                m_left <= is_vec(opcode) ? LANES : 0;
                m_res  <= expect_result(opcode, op_1, op_2);
                m_ill  <= expect_ill(opcode);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            logic [63:0] exp_ops;
            logic [15:0] la, lb;
            int          lane;
            check("in_ready",  VW'(in_ready),  VW'(!m_busy));
            check("out_valid", VW'(out_valid), VW'(m_busy && m_left == 0));
            check("busy",      VW'(busy),      VW'(m_busy));
            if (m_busy && m_left == 0) begin
                check("result", result, m_res);
`ifdef VALU_ILLEGAL_CHK_EN
                check("illegal", VW'(illegal), VW'(m_ill));
`endif
            end
            exp_ops = '0;
            if (m_busy && m_left > 0) begin
                lane = LANES - m_left;
                la   = m_a[lane*LW +: LW];
                lb   = m_b[lane*LW +: LW];
                case (m_op)
                    4'd0: exp_ops = {la, lb, 16'h0, 16'h0};
                    4'd2: exp_ops = {16'h0, 16'h0, m_b[LW-1:0], la};
                    4'd1: exp_ops = {dot_acc(m_a, m_b, lane), f_mul(la, lb), la, lb};
                    default: exp_ops = '0;
                endcase
            end
            check("fu_operands", VW'({fadd_a, fadd_b, fmul_a, fmul_b}), VW'(exp_ops));
        end
    end

    // ---------------- stimulus -------------------------------------------
    function automatic logic [15:0] rand_lane();
        case ($urandom % 9)
            0: return 16'h0000;
            1: return 16'h3C00;
            2: return 16'h4000;
            3: return 16'h4200;
            4: return 16'h4400;
            5: return 16'h3800;
            6: return 16'hBC00;
            7: return 16'hC000;
            default: return 16'hC200;
        endcase
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*LW +: LW] = rand_lane();
        return v;
    endfunction

    // Called at posedge+#1; returns with out_valid visible (or timeout)
    task automatic issue(input logic [3:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         output int lat, output int ready_seen);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        end
        opcode   = op;
        op_1     = a;
        op_2     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        lat        = 0;
        ready_seen = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_seen++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    localparam logic [VW-1:0] ONES   = {LANES{16'h3C00}};
    localparam logic [VW-1:0] TWOS   = {LANES{16'h4000}};
    localparam logic [VW-1:0] THREES = {LANES{16'h4200}};

    initial begin
        int            lat, rs;
        logic [VW-1:0] hold, v;

        rst_n = 1'b0; in_valid = 1'b0; opcode = 4'd0; op_1 = '0; op_2 = '0; out_ready = 1'b1;

        // Model pins: hand-computed expectations for the reference model itself
        check("model_vadd", expect_result(4'd0, ONES, TWOS), THREES);
        check("model_vdot", expect_result(4'd1, ONES, TWOS), {240'h0, 16'h5000});
        check("model_smul", expect_result(4'd2, THREES, {240'h0, 16'h4000}), {LANES{16'h4600}});

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  VW'(in_ready),  VW'(1'b1));
        check("rst_out_valid", VW'(out_valid), VW'(1'b0));
        check("rst_busy",      VW'(busy),      VW'(1'b0));
        check("rst_result",    result,         '0);
        rst_n = 1'b1;

        // VADD 1.0 + 2.0
        issue(4'd0, ONES, TWOS, lat, rs);
        check("vadd_latency", VW'(lat), VW'(16));
        check("vadd_ready_low", VW'(rs), VW'(0));
        check("vadd_result", result, THREES);
        @(posedge clk); #1;
        check("handshake_ready", VW'(in_ready), VW'(1'b1));

        // VDOT
        issue(4'd1, ONES, TWOS, lat, rs);
        check("vdot_result", result, {240'h0, 16'h5000});
        @(posedge clk); #1;

        // SMUL with random upper op_2 lanes
        v = rand_vec();
        v[15:0] = 16'h4000;
        issue(4'd2, THREES, v, lat, rs);
        check("smul_result", result, {LANES{16'h4600}});
        @(posedge clk); #1;

        // Backpressure: five stalled cycles then handshake
        out_ready = 1'b0;
        issue(4'd0, ONES, TWOS, lat, rs);
        hold = result;
        check("bp_result_first", hold, THREES);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom % 2);
            opcode   = 4'hF;
            @(posedge clk); #1;
            check("bp_result",    result,         hold);
            check("bp_out_valid", VW'(out_valid), VW'(1'b1));
            check("bp_busy",      VW'(busy),      VW'(1'b1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after", VW'(in_ready), VW'(1'b1));

        // Reset in the middle of a VDOT, at lane 7
        opcode = 4'd1; op_1 = ONES; op_2 = TWOS; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  VW'(in_ready),  VW'(1'b1));
        check("mid_rst_out_valid", VW'(out_valid), VW'(1'b0));
        check("mid_rst_busy",      VW'(busy),      VW'(1'b0));
        check("mid_rst_result",    result,         '0);
        check("mid_rst_fu",        VW'({fadd_a, fadd_b, fmul_a, fmul_b}), '0);
`ifdef VALU_ILLEGAL_CHK_EN
        check("mid_rst_illegal",   VW'(illegal),   VW'(1'b0));
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(4'd0, ONES, TWOS, lat, rs);
        check("post_rst_vadd", result, THREES);
        @(posedge clk); #1;

        // Unassigned opcode 1010
        issue(4'hA, ONES, TWOS, lat, rs);
        check("op1010_latency", VW'(lat), VW'(0));
        check("op1010_result",  result,   '0);
`ifdef VALU_ILLEGAL_CHK_EN
        check("op1010_illegal", VW'(illegal), VW'(1'b1));
`endif
        @(posedge clk); #1;

        // NOP
        issue(4'hF, ONES, TWOS, lat, rs);
        check("nop_latency", VW'(lat), VW'(0));
        check("nop_result",  result,   '0);
`ifdef VALU_ILLEGAL_CHK_EN
        check("nop_illegal", VW'(illegal), VW'(1'b0));
`endif
        @(posedge clk); #1;

        // Randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 3) != 0;
            opcode    = ($urandom % 4 != 0) ? 4'($urandom % 3) : 4'($urandom % 16);
            op_1      = rand_vec();
            op_2      = rand_vec();
            out_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end

        // Drain
        in_valid  = 1'b0;
        out_ready = 1'b1;
        begin
            int guard;
            guard = 0;
            while (busy && guard < 40) begin
                @(posedge clk); #1;
                guard++;
            end
            check("drain_idle", VW'(busy), VW'(1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
